// File: rtl/gate_exerciser_if.sv
// Purpose: bundles the handshake and gate-block stimulus/response signals of
//          gate_exerciser.
// Ports (signals):
//   start     : begin a run (environment -> exerciser)
//   a, b      : operands driven into the gate block (exerciser -> gate)
//   res[5:0]  : gate outputs {c,d,e,f,g,h} (gate -> exerciser)
//   busy      : run in progress
//   done      : one-cycle completion pulse
//   pass      : verdict of the last run
//   err_count : failing-vector count of the last run, saturating
//   fail_vec  : {a,b} of the first failing vector
// Modports: master = exerciser side, slave = environment/gate side.
interface gate_exerciser_if #(
    parameter int unsigned ERR_W = 3
);
    logic             start;
    logic             a;
    logic             b;
    logic [5:0]       res;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       fail_vec;

    modport master (
        input  start, res,
        output a, b, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        output start, res,
        input  a, b, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_exerciser.sv
// Purpose: bring-up checker for the 2-input basic-gate block. On start it walks
//          {a,b} through 00,01,10,11, holds each vector SETTLE_CYCLES cycles,
//          then compares the six gate outputs against the golden truth table.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : gate_exerciser_if.master (start, res in; a, b, busy, done, pass,
//          err_count, fail_vec out, all outputs registered)
module gate_exerciser #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [5:0]  CHECK_MASK    = 6'b111111,
    parameter int unsigned ERR_W         = 3
) (
    input  logic             clk,
    input  logic             rst,
    gate_exerciser_if.master bus
);
    localparam int unsigned      CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       vec_q, vec_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [1:0]       fail_vec_q, fail_vec_d;

    logic [5:0]       golden_c;
    logic             mismatch_c;

    // Golden truth table for the operands currently driven: {c,d,e,f,g,h}
    always_comb begin
        golden_c   = {a_q & b_q, a_q | b_q, a_q ^ b_q, ~a_q, ~(a_q & b_q), ~(a_q ^ b_q)};
        mismatch_c = |((bus.res ^ golden_c) & CHECK_MASK);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_d       = vec_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        fail_vec_d  = fail_vec_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    vec_d       = 2'd0;
                    a_d         = 1'b0;
                    b_d         = 1'b0;
                    err_count_d = '0;
                    fail_vec_d  = 2'd0;
                    pass_d      = 1'b0;
                    busy_d      = 1'b1;
                    cnt_d       = CNT_LOAD;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch_c) begin
                    if (err_count_q != ERR_MAX) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                    // An empty count means this is the run's first failure
                    if (err_count_q == '0) begin
                        fail_vec_d = vec_q;
                    end
                end
                if (vec_q == 2'd3) begin
                    // Verdict and done are registered on entry to DONE
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == '0);
                    state_d = DONE;
                end else begin
                    vec_d      = vec_q + 2'd1;
                    {a_d, b_d} = vec_d;
                    cnt_d      = CNT_LOAD;
                    state_d    = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vec_q       <= 2'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            fail_vec_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_q       <= vec_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            fail_vec_q  <= fail_vec_d;
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_count_q;
    assign bus.fail_vec  = fail_vec_q;
endmodule

// File: tb/tb_gate_exerciser.sv
// Purpose: directed self-checking bench for gate_exerciser. Three instances:
//   dut0 (S=1, full mask), dutm (S=1, mask 111101), dut3 (S=3, full mask).
//   Each drives a behavioural gate model with a stuck-at-0 fault mask.
module tb_gate_exerciser;
    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] sel;
    logic [5:0] fault0;
    logic [5:0] faultm;
    logic [5:0] fault3;

    int n_checks;
    int n_fail;

    gate_exerciser_if #(.ERR_W(3)) bus0 ();
    gate_exerciser_if #(.ERR_W(3)) busm ();
    gate_exerciser_if #(.ERR_W(3)) bus3 ();

    gate_exerciser #(.SETTLE_CYCLES(1), .CHECK_MASK(6'b111111), .ERR_W(3)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    gate_exerciser #(.SETTLE_CYCLES(1), .CHECK_MASK(6'b111101), .ERR_W(3)) dutm (
        .clk(clk), .rst(rst), .bus(busm)
    );
    gate_exerciser #(.SETTLE_CYCLES(3), .CHECK_MASK(6'b111111), .ERR_W(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    // Behavioural gate block: {and, or, xor, not a, nand, xnor}
    function automatic logic [5:0] gate_model(input logic a, input logic b);
        logic [5:0] r;
        r[5] = a & b;
        r[4] = a | b;
        r[3] = a ^ b;
        r[2] = ~a;
        r[1] = ~(a & b);
        r[0] = ~(a ^ b);
        return r;
    endfunction

    assign bus0.start = start && (sel == 2'd0);
    assign busm.start = start && (sel == 2'd1);
    assign bus3.start = start && (sel == 2'd2);
    assign bus0.res   = gate_model(bus0.a, bus0.b) & ~fault0;
    assign busm.res   = gate_model(busm.a, busm.b) & ~faultm;
    assign bus3.res   = gate_model(bus3.a, bus3.b) & ~fault3;

    // Observation mux onto the selected instance
    logic       o_a, o_b, o_busy, o_done, o_pass;
    logic [2:0] o_err;
    logic [1:0] o_fv;
    always_comb begin
        o_a = bus0.a; o_b = bus0.b; o_busy = bus0.busy; o_done = bus0.done;
        o_pass = bus0.pass; o_err = bus0.err_count; o_fv = bus0.fail_vec;
        if (sel == 2'd1) begin
            o_a = busm.a; o_b = busm.b; o_busy = busm.busy; o_done = busm.done;
            o_pass = busm.pass; o_err = busm.err_count; o_fv = busm.fail_vec;
        end else if (sel == 2'd2) begin
            o_a = bus3.a; o_b = bus3.b; o_busy = bus3.busy; o_done = bus3.done;
            o_pass = bus3.pass; o_err = bus3.err_count; o_fv = bus3.fail_vec;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One start pulse; cycle i counts negedges after the accepting edge T
    task automatic do_run(input int s, input string tag, input logic exp_pass,
                          input int exp_err, input logic [1:0] exp_fv);
        int last;
        last  = 4 * (s + 1) + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= last; i++) begin
            if (i < last)
                check_eq($sformatf("%s ab c%0d", tag, i), 32'({o_a, o_b}), 32'((i - 1) / (s + 1)));
            check_eq($sformatf("%s busy c%0d", tag, i), 32'(o_busy), 32'(i < last));
            check_eq($sformatf("%s done c%0d", tag, i), 32'(o_done), 32'(i == last));
            if (i < last) @(negedge clk);
        end
        check_eq({tag, " pass"}, 32'(o_pass), 32'(exp_pass));
        check_eq({tag, " err"}, 32'(o_err), 32'(exp_err));
        check_eq({tag, " fail_vec"}, 32'(o_fv), 32'(exp_fv));
        @(negedge clk);
        check_eq({tag, " done drop"}, 32'(o_done), 32'd0);
        check_eq({tag, " pass hold"}, 32'(o_pass), 32'(exp_pass));
    endtask

    initial begin
        int dcount;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        sel      = 2'd0;
        fault0   = 6'd0;
        faultm   = 6'd0;
        fault3   = 6'd0;

        // Reset state on every instance
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = 2'(k);
            #1;
            check_eq($sformatf("rst%0d ab", k), 32'({o_a, o_b}), 32'd0);
            check_eq($sformatf("rst%0d busy", k), 32'(o_busy), 32'd0);
            check_eq($sformatf("rst%0d done", k), 32'(o_done), 32'd0);
            check_eq($sformatf("rst%0d pass", k), 32'(o_pass), 32'd0);
            check_eq($sformatf("rst%0d err", k), 32'(o_err), 32'd0);
            check_eq($sformatf("rst%0d fv", k), 32'(o_fv), 32'd0);
        end
        sel = 2'd0;
        rst = 1'b0;
        @(negedge clk);

        // Ideal gates
        do_run(1, "t1", 1'b1, 0, 2'b00);

        // d stuck-at-0: 01,10,11 fail
        fault0 = 6'b010000;
        do_run(1, "t2", 1'b0, 3, 2'b01);

        // g stuck-at-0, masked off vs. checked: 00,01,10 fail
        fault0 = 6'b000010;
        faultm = 6'b000010;
        sel    = 2'd1;
        do_run(1, "t3m", 1'b1, 0, 2'b00);
        sel    = 2'd0;
        do_run(1, "t3d", 1'b0, 3, 2'b00);
        fault0 = 6'd0;
        faultm = 6'd0;

        // start held for 12 accepting edges: runs accepted at T and T+10
        start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 12) start = 1'b0;
            check_eq($sformatf("t4 done c%0d", i), 32'(o_done), 32'((i == 9) || (i == 19)));
            check_eq($sformatf("t4 busy c%0d", i), 32'(o_busy),
                     32'(((i >= 1) && (i <= 8)) || ((i >= 11) && (i <= 18))));
            if (i == 19) check_eq("t4 pass", 32'(o_pass), 32'd1);
        end

        // h stuck-at-0 fails vector 00; reset during SETTLE of vector 10
        fault0 = 6'b000001;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("t5 ab pre", 32'({o_a, o_b}), 32'b10);
        check_eq("t5 err pre", 32'(o_err), 32'd1);
        check_eq("t5 fv pre", 32'(o_fv), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t5 busy", 32'(o_busy), 32'd0);
        check_eq("t5 ab", 32'({o_a, o_b}), 32'd0);
        check_eq("t5 err", 32'(o_err), 32'd0);
        check_eq("t5 done", 32'(o_done), 32'd0);
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_done) dcount++;
        end
        check_eq("t5 no done", 32'(dcount), 32'd0);
        fault0 = 6'd0;
        do_run(1, "t5c", 1'b1, 0, 2'b00);

        // SETTLE_CYCLES=3: each vector held 4 cycles, done at T+17
        sel = 2'd2;
        do_run(3, "t6", 1'b1, 0, 2'b00);
        fault3 = 6'b100000;
        do_run(3, "t6f", 1'b0, 1, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
